// File: rtl/ir_pkg.sv
// Shared types and helpers for the IR key dispatcher.
package ir_pkg;

   localparam logic [15:0] NEC_ADDR_DEFAULT = 16'h0707;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      HOLD   = 2'd2,
      REPEAT = 2'd3
   } disp_state_e;

   // NEC frame as the encoder expects it: {~C, C, address}
   function automatic logic [31:0] nec_frame(input logic [7:0] c, input logic [15:0] addr);
      return {~c, c, addr};
   endfunction

endpackage

// File: rtl/ir_key_dispatcher_if.sv
// Frame request channel between the key dispatcher and ir_encoder.
interface ir_key_dispatcher_if;
   logic [31:0] cmd;
   logic        valid;
   logic        repeat_frame;
   logic        ready;

   modport master (output cmd, output valid, output repeat_frame, input ready);
   modport slave  (input cmd, input valid, input repeat_frame, output ready);
endinterface

// File: rtl/key_debouncer.sv
// One key: 2-FF synchroniser, consecutive-cycle debounce, press pulse.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk25,
   input  logic rst,
   input  logic key_raw,
   output logic key_deb,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] cnt;

   // synchronise, count cycles of disagreement, flip after the full run
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         cnt     <= '0;
         key_deb <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_1 <= key_raw;
         sync_2 <= sync_1;
         press  <= 1'b0;
         if (sync_2 == key_deb) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt     <= '0;
            key_deb <= sync_2;
            press   <= sync_2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ir_key_dispatcher.sv
// Key-to-NEC dispatcher: debounced keys -> frame requests for ir_encoder.
// Optional hold-to-repeat is built when IR_DISPATCH_REPEAT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a press event
// SEND   | first frame offered, waiting for ready
// HOLD   | frame taken; waiting for release (or repeat interval)
// REPEAT | NEC repeat code offered, waiting for ready
module ir_key_dispatcher
   import ir_pkg::*;
#(
   parameter int                   N_KEYS          = 4,
   parameter int                   DEBOUNCE_CYCLES = 250000,
   parameter int                   REPEAT_CYCLES   = 2700000,
   parameter logic [15:0]          NEC_ADDR        = NEC_ADDR_DEFAULT,
   parameter logic [N_KEYS*8-1:0]  CMD_TABLE       = {8'h65, 8'h61, 8'h60, 8'h62}
) (
   input  logic                clk25,
   input  logic                rst,
   input  logic [N_KEYS-1:0]   key,
   ir_key_dispatcher_if.master enc,
   output logic                busy,
   output logic [7:0]          dropped
);

   localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

   logic [N_KEYS-1:0] key_deb;
   logic [N_KEYS-1:0] press;
   logic              sel_hit;
   logic [IDX_W-1:0]  sel_idx;
   logic [4:0]        press_cnt;
   logic [4:0]        drop_inc;
   logic [8:0]        drop_sum;
   disp_state_e       state;
   disp_state_e       state_nxt;
   logic              load;
   logic [IDX_W-1:0]  key_idx;
   logic [31:0]       cmd_q;
   logic              held;
   logic              timer_done;

   genvar gi;
   generate
      for (gi = 0; gi < N_KEYS; gi++) begin : g_key
         key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk25   (clk25),
            .rst     (rst),
            .key_raw (key[gi]),
            .key_deb (key_deb[gi]),
            .press   (press[gi])
         );
      end
   endgenerate

   // lowest-index press wins; count all presses for the drop counter
   always_comb begin
      sel_hit   = 1'b0;
      sel_idx   = '0;
      press_cnt = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (press[i]) begin
            sel_hit   = 1'b1;
            sel_idx   = IDX_W'(i);
            press_cnt = press_cnt + 5'd1;
         end
      end
   end

   assign held = key_deb[key_idx];

`ifdef IR_DISPATCH_REPEAT_EN
   localparam int TMR_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   logic [TMR_W-1:0] timer;

   // repeat interval runs only while holding; zero on entry to HOLD
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst)                timer <= '0;
      else if (state == HOLD) timer <= timer + 1'b1;
      else                    timer <= '0;
   end

   assign timer_done       = (timer == TMR_W'(REPEAT_CYCLES - 1));
   assign enc.repeat_frame = (state == REPEAT);
`else
   assign timer_done       = 1'b0;
   assign enc.repeat_frame = 1'b0;
`endif

   // state register
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (sel_hit) begin
               state_nxt = SEND;
               load      = 1'b1;
            end
         end
         SEND:   if (enc.ready) state_nxt = HOLD;
         HOLD: begin
            if (!held)           state_nxt = IDLE;
            else if (timer_done) state_nxt = REPEAT;
         end
         REPEAT: if (enc.ready) state_nxt = HOLD;
         default: state_nxt = IDLE;
      endcase
   end

   // latch the selected key and its frame when leaving IDLE
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         key_idx <= '0;
         cmd_q   <= '0;
      end else if (load) begin
         key_idx <= sel_idx;
         cmd_q   <= nec_frame(CMD_TABLE[{sel_idx, 3'b000} +: 8], NEC_ADDR);
      end
   end

   // the accepted press in IDLE is not a drop; everything else is
   always_comb begin
      drop_inc = press_cnt;
      if (state == IDLE && sel_hit) drop_inc = press_cnt - 5'd1;
      drop_sum = {1'b0, dropped} + {4'b0000, drop_inc};
   end

   // saturating drop counter, cleared only by reset
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) dropped <= '0;
      else     dropped <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   assign enc.valid = (state == SEND) || (state == REPEAT);
   assign enc.cmd   = cmd_q;
   assign busy      = (state != IDLE);

endmodule
